gelato_fetch_scheduler: RTL and testbench

Consumer end of the PC-table / fetch-scheduler link. The split tables drive a per-warp PC offer and a one-shot warp re-activation pulse. This block picks one eligible warp per cycle using round-robin arbitration and registers its PC and split-table entry into a fetch request slot for the instruction fetch stage. It then marks that warp pending until the split table re-activates it after decode.

---
 rtl/gelato_fetch_scheduler_if.sv | 39 +++
 rtl/gelato_fetch_scheduler.sv | 88 ++++++++
 tb/tb_gelato_fetch_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gelato_fetch_scheduler_if.sv
// gelato_fetch_scheduler_if
//   Link between the split/PC tables, the fetch scheduler and the fetch stage.
//   master : environment side (tables drive offers and re-activation, the
//            fetch stage drives fetch_ready)
//   slave  : the scheduler (consumes offers, drives the fetch request slot)
//   Signals:
//     pc_valid / pc / split_table_num      per-warp PC offer
//     activate_valid / activate_warp_num   one-shot warp re-activation
//     fetch_valid / fetch_ready            fetch request handshake
//     fetch_warp_num / fetch_pc / fetch_split_table_num  request payload
//     pending                              per-warp in-flight flags
interface gelato_fetch_scheduler_if #(
  parameter int WARP_NUM        = 4,
  parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM),
  parameter int PC_WIDTH        = 32,
  parameter int SPLIT_NUM_WIDTH = 2
);
  logic [WARP_NUM-1:0]                      pc_valid;
  logic [WARP_NUM-1:0][PC_WIDTH-1:0]        pc;
  logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0] split_table_num;
  logic                                     activate_valid;
  logic [WARP_NUM_WIDTH-1:0]                activate_warp_num;
  logic                                     fetch_valid;
  logic                                     fetch_ready;
  logic [WARP_NUM_WIDTH-1:0]                fetch_warp_num;
  logic [PC_WIDTH-1:0]                      fetch_pc;
  logic [SPLIT_NUM_WIDTH-1:0]               fetch_split_table_num;
  logic [WARP_NUM-1:0]                      pending;

  modport master (
    output pc_valid, pc, split_table_num, activate_valid, activate_warp_num, fetch_ready,
    input  fetch_valid, fetch_warp_num, fetch_pc, fetch_split_table_num, pending
  );

  modport slave (
    input  pc_valid, pc, split_table_num, activate_valid, activate_warp_num, fetch_ready,
    output fetch_valid, fetch_warp_num, fetch_pc, fetch_split_table_num, pending
  );
endinterface

// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler
//   Picks one eligible warp per cycle (round-robin, starting after the last
//   grant), registers its PC and split entry into a single fetch request slot
//   and marks the warp pending until the split table re-activates it.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     rdy  global enable; low freezes all state and outputs
//     bus  scheduler side (slave) of gelato_fetch_scheduler_if
module gelato_fetch_scheduler #(
  parameter int WARP_NUM        = 4,
  parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM),
  parameter int PC_WIDTH        = 32,
  parameter int SPLIT_NUM_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  gelato_fetch_scheduler_if.slave  bus
);

  typedef struct packed {
    logic [WARP_NUM_WIDTH-1:0]  warp;
    logic [PC_WIDTH-1:0]        pc;
    logic [SPLIT_NUM_WIDTH-1:0] split;
  } fetch_req_t;

  logic [WARP_NUM-1:0]       pending_q, pending_nxt, eligible;
  logic [WARP_NUM_WIDTH-1:0] last_grant, win, idx;
  logic                      found, slot_free, grant, fetch_valid_q;
  fetch_req_t                slot_q;

  for (genvar g = 0; g < WARP_NUM; g++) begin : g_elig
    assign eligible[g] = bus.pc_valid[g] & ~pending_q[g];
  end

  // Search last_grant+1 .. last_grant+WARP_NUM; the index wraps naturally
  // because WARP_NUM is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= WARP_NUM; k++) begin
      idx = last_grant + WARP_NUM_WIDTH'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign slot_free = ~fetch_valid_q | bus.fetch_ready;
  assign grant     = rdy & slot_free & found;

  // Clear from activation first, then set from grant so a same-cycle grant wins.
  always_comb begin
    pending_nxt = pending_q;
    if (bus.activate_valid) pending_nxt[bus.activate_warp_num] = 1'b0;
    if (grant)              pending_nxt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      last_grant    <= WARP_NUM_WIDTH'(WARP_NUM - 1);
      fetch_valid_q <= 1'b0;
      slot_q        <= '0;
    end else if (rdy) begin
      pending_q <= pending_nxt;
      if (slot_free) begin
        fetch_valid_q <= found;
        if (found) begin
          slot_q.warp  <= win;
          slot_q.pc    <= bus.pc[win];
          slot_q.split <= bus.split_table_num[win];
          last_grant   <= win;
        end
      end
    end
  end

  assign bus.fetch_valid           = fetch_valid_q;
  assign bus.fetch_warp_num        = slot_q.warp;
  assign bus.fetch_pc              = slot_q.pc;
  assign bus.fetch_split_table_num = slot_q.split;
  assign bus.pending               = pending_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
module tb_gelato_fetch_scheduler;
  localparam int WN = 4;

  logic clk = 1'b0;
  logic rst, rdy;
  int   tests = 0;
  int   fails = 0;

  gelato_fetch_scheduler_if #(.WARP_NUM(WN), .PC_WIDTH(32), .SPLIT_NUM_WIDTH(2)) bus ();

  gelato_fetch_scheduler #(.WARP_NUM(WN), .PC_WIDTH(32), .SPLIT_NUM_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic fv, input int w, input logic [3:0] pend);
    chk({tag, ".valid"}, 64'(bus.fetch_valid), 64'(fv));
    if (fv) chk({tag, ".warp"}, 64'(bus.fetch_warp_num), 64'(w));
    chk({tag, ".pending"}, 64'(bus.pending), 64'(pend));
  endtask

  task automatic act(input logic v, input int w);
    bus.activate_valid    = v;
    bus.activate_warp_num = 2'(w);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.pc_valid = '0;
    bus.fetch_ready = 1'b0;
    act(1'b0, 0);
    for (int i = 0; i < WN; i++) begin
      bus.pc[i]              = 32'h100 + 32'(i) * 32'h10;
      bus.split_table_num[i] = 2'(3 - i);
    end
    step(); step();
    chk("rst.valid", 64'(bus.fetch_valid), 64'd0);
    chk("rst.warp", 64'(bus.fetch_warp_num), 64'd0);
    chk("rst.pc", 64'(bus.fetch_pc), 64'd0);
    chk("rst.split", 64'(bus.fetch_split_table_num), 64'd0);
    chk("rst.pending", 64'(bus.pending), 64'd0);
    rst = 1'b0;

    // 1: single warp, grant, idle, re-activate, regrant two cycles after pulse
    bus.pc_valid = 4'b0001;
    bus.fetch_ready = 1'b1;
    step();
    chk_slot("t1.grant", 1'b1, 0, 4'b0001);
    chk("t1.pc", 64'(bus.fetch_pc), 64'h100);
    chk("t1.split", 64'(bus.fetch_split_table_num), 64'd3);
    step();
    chk_slot("t1.idle0", 1'b0, 0, 4'b0001);
    step();
    chk_slot("t1.idle1", 1'b0, 0, 4'b0001);
    act(1'b1, 0);
    step();
    act(1'b0, 0);
    chk_slot("t1.cleared", 1'b0, 0, 4'b0000);
    step();
    chk_slot("t1.regrant", 1'b1, 0, 4'b0001);

    // 2: all warps from fresh reset
    rst = 1'b1;
    bus.pc_valid = '0;
    step();
    rst = 1'b0;
    bus.pc_valid = 4'b1111;
    step(); chk_slot("t2.g0", 1'b1, 0, 4'b0001);
    step(); chk_slot("t2.g1", 1'b1, 1, 4'b0011);
    step(); chk_slot("t2.g2", 1'b1, 2, 4'b0111);
    chk("t2.pc2", 64'(bus.fetch_pc), 64'h120);
    chk("t2.split2", 64'(bus.fetch_split_table_num), 64'd1);
    step(); chk_slot("t2.g3", 1'b1, 3, 4'b1111);
    step(); chk_slot("t2.idle", 1'b0, 0, 4'b1111);
    act(1'b1, 2);
    step(); chk_slot("t2.act2", 1'b0, 0, 4'b1011);
    act(1'b1, 0);
    step(); chk_slot("t2.re2", 1'b1, 2, 4'b1110);
    act(1'b0, 0);
    step(); chk_slot("t2.re0", 1'b1, 0, 4'b1111);

    // 3: backpressure with warp 1 made eligible
    bus.fetch_ready = 1'b0;
    act(1'b1, 1);
    step(); chk_slot("t3.hold0", 1'b1, 0, 4'b1101);
    act(1'b0, 0);
    step(); chk_slot("t3.hold1", 1'b1, 0, 4'b1101);
    step(); chk_slot("t3.hold2", 1'b1, 0, 4'b1101);
    chk("t3.pc", 64'(bus.fetch_pc), 64'h100);
    bus.fetch_ready = 1'b1;
    step(); chk_slot("t3.next", 1'b1, 1, 4'b1111);
    chk("t3.pc1", 64'(bus.fetch_pc), 64'h110);

    // 4: same-cycle grant and activate; activate of a non-pending warp
    bus.pc_valid = 4'b0010;
    act(1'b1, 1);
    step(); chk_slot("t4.clr1", 1'b0, 0, 4'b1101);
    step(); chk_slot("t4.setwins", 1'b1, 1, 4'b1111);
    bus.pc_valid = 4'b0000;
    act(1'b1, 3);
    step(); chk_slot("t4.clr3", 1'b0, 0, 4'b0111);
    step(); chk_slot("t4.nonpend3", 1'b0, 0, 4'b0111);
    act(1'b0, 0);

    // 5: rdy low freezes everything and drops the activate pulse
    bus.pc_valid = 4'b1111;
    rdy = 1'b0;
    act(1'b1, 0);
    step(); chk_slot("t5.frz0", 1'b0, 0, 4'b0111);
    act(1'b0, 0);
    step(); chk_slot("t5.frz1", 1'b0, 0, 4'b0111);
    rdy = 1'b1;
    step(); chk_slot("t5.resume", 1'b1, 3, 4'b1111);
    chk("t5.pc3", 64'(bus.fetch_pc), 64'h130);
    chk("t5.split3", 64'(bus.fetch_split_table_num), 64'd0);

    // 6: reset mid-flight with pending=1011
    bus.pc_valid = 4'b0000;
    bus.fetch_ready = 1'b0;
    act(1'b1, 2);
    step(); chk_slot("t6.pre", 1'b1, 3, 4'b1011);
    act(1'b0, 0);
    rst = 1'b1;
    bus.pc_valid = 4'b0110;
    step(); chk_slot("t6.rst", 1'b0, 0, 4'b0000);
    chk("t6.rstwarp", 64'(bus.fetch_warp_num), 64'd0);
    rst = 1'b0;
    step(); chk_slot("t6.first", 1'b1, 1, 4'b0010);
    chk("t6.pc1", 64'(bus.fetch_pc), 64'h110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
